// File: rtl/ring_osc_meter_ctrl.sv
// Ring-oscillator frequency meter. Enables one selected oscillator, lets it settle,
// counts its synchronized rising edges over a gate window, then returns the count.
module ring_osc_meter_ctrl #(
    parameter int NUM_OSC       = 4,
    parameter int SEL_W         = 2,
    parameter int CNT_W         = 16,
    parameter int GATE_W        = 16,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SEL_W-1:0]   sel,
    input  logic [GATE_W-1:0]  gate_len,
    input  logic [NUM_OSC-1:0] osc_tap,
    output logic [NUM_OSC-1:0] osc_en,
    output logic               busy,
    output logic [CNT_W-1:0]   result,
    output logic               overflow,
    output logic               err,
    output logic               result_valid,
    input  logic               result_ready
);

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

    localparam int          SETTLE_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [31:0] NUM_OSC_U = 32'(NUM_OSC);

    state_t              state, state_d;
    logic [SEL_W-1:0]    sel_q;
    logic [GATE_W-1:0]   gate_q;
    logic [GATE_W-1:0]   gate_cnt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_d;
    logic                ovf_d;
    logic                tap_bit;
    logic                sync1;
    logic                sync2;
    logic                prev;
    logic                edge_hit;
    logic                req_bad;

    // An out-of-range latched select reads as a quiet tap.
    always_comb begin
        tap_bit = 1'b0;
        for (int i = 0; i < NUM_OSC; i++) begin
            if (32'(sel_q) == 32'(i)) tap_bit = osc_tap[i];
        end
    end

    assign req_bad  = (32'(sel) >= NUM_OSC_U) || (gate_len == '0);
    assign edge_hit = (state == MEASURE) && sync2 && !prev;

    always_comb begin
        count_d = count;
        ovf_d   = overflow;
        if (edge_hit) begin
            if (&count) ovf_d = 1'b1;
            else        count_d = count + CNT_W'(1);
        end
    end

    // Result handshake: result_valid is high exactly while in DONE; a transfer happens
    // on a clk edge where result_valid and result_ready are both 1, and result,
    // overflow and err hold steady from the rise of result_valid until that transfer.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = req_bad ? DONE : SETTLE;
            SETTLE:  if (settle_cnt == '0) state_d = MEASURE;
            MEASURE: if (gate_cnt == '0) state_d = DONE;
            DONE:    if (result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sel_q        <= '0;
            gate_q       <= '0;
            gate_cnt     <= '0;
            settle_cnt   <= '0;
            count        <= '0;
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            prev         <= 1'b0;
            osc_en       <= '0;
            busy         <= 1'b0;
            result       <= '0;
            overflow     <= 1'b0;
            err          <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state <= state_d;
            busy  <= (state_d != IDLE);
            sync1 <= tap_bit;
            sync2 <= sync1;
            prev  <= sync2;
            case (state)
                IDLE: begin
                    if (start) begin
                        sel_q      <= sel;
                        gate_q     <= gate_len;
                        count      <= '0;
                        overflow   <= 1'b0;
                        settle_cnt <= SETTLE_W'(SETTLE_CYCLES - 1);
                        if (req_bad) begin
                            err          <= 1'b1;
                            result       <= '0;
                            result_valid <= 1'b1;
                        end else begin
                            err    <= 1'b0;
                            osc_en <= NUM_OSC'(1) << sel;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt == '0) gate_cnt <= gate_q - GATE_W'(1);
                    else                  settle_cnt <= settle_cnt - SETTLE_W'(1);
                end
                MEASURE: begin
                    count    <= count_d;
                    overflow <= ovf_d;
                    if (gate_cnt == '0) begin
                        osc_en       <= '0;
                        result       <= count_d;
                        result_valid <= 1'b1;
                    end else begin
                        gate_cnt <= gate_cnt - GATE_W'(1);
                    end
                end
                DONE: begin
                    if (result_ready) result_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_osc_meter_ctrl.sv
// Bench for ring_osc_meter_ctrl: a 16-bit and a 4-bit counter instance share all inputs;
// edge counts are predicted from the recorded tap history.
module tb_ring_osc_meter_ctrl;

    localparam int NUM_OSC = 4;
    localparam int S       = 8;
    localparam int HN      = 65536;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  sel;
    logic [15:0] gate_len;
    logic [3:0]  osc_tap;
    logic        result_ready;

    logic [3:0]  osc_en,   osc_en_s;
    logic        busy,     busy_s;
    logic [15:0] result;
    logic [3:0]  result_s;
    logic        overflow, overflow_s;
    logic        err,      err_s;
    logic        result_valid, result_valid_s;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          tap_mode = 0;
    int unsigned ph       = 0;
    logic [3:0]  hist [HN];

    ring_osc_meter_ctrl #(.NUM_OSC(NUM_OSC), .SEL_W(3), .CNT_W(16), .GATE_W(16),
                          .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .start(start), .sel(sel), .gate_len(gate_len),
        .osc_tap(osc_tap), .osc_en(osc_en), .busy(busy), .result(result),
        .overflow(overflow), .err(err), .result_valid(result_valid),
        .result_ready(result_ready)
    );

    ring_osc_meter_ctrl #(.NUM_OSC(NUM_OSC), .SEL_W(3), .CNT_W(4), .GATE_W(16),
                          .SETTLE_CYCLES(S)) dut_s (
        .clk(clk), .rst(rst), .start(start), .sel(sel), .gate_len(gate_len),
        .osc_tap(osc_tap), .osc_en(osc_en_s), .busy(busy_s), .result(result_s),
        .overflow(overflow_s), .err(err_s), .result_valid(result_valid_s),
        .result_ready(result_ready)
    );

    // clock / tap stimulus / tap history
    always #5 clk = ~clk;

    initial begin
        osc_tap = 4'h0;
        forever begin
            @(negedge clk);
            ph++;
            case (tap_mode)
                0:       osc_tap = {ph[1], ph[1], ~ph[1], ph[2]};
                1:       osc_tap = 4'($urandom);
                2:       osc_tap = {4{ph[0]}};
                default: osc_tap = osc_tap ^ 4'($urandom & $urandom);
            endcase
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            hist[cyc % HN] = osc_tap;
            cyc++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // At most one oscillator enabled, and only while the controller is busy.
    initial begin
        forever begin
            @(negedge clk);
            chk("onehot_en", 32'($countones(osc_en)) <= 32'd1, 1);
            chk("en_only_busy", (osc_en == 4'h0) || busy, 1);
            chk("onehot_en_s", ((osc_en_s == 4'h0) || busy_s) && ($countones(osc_en_s) <= 1), 1);
        end
    end

    // One measurement from request to handshake; called at a negedge with the DUT idle.
    task automatic run_meas(input int s, input int g, input int hold, input bit hs_start,
                            input bit nominal);
        int          t;
        int          n;
        int          edges;
        bit          bad;
        logic [15:0] exp_res;
        logic [3:0]  exp_res_s;
        bad          = (s >= NUM_OSC) || (g == 0);
        start        = 1'b1;
        sel          = 3'(s);
        gate_len     = 16'(g);
        result_ready = 1'b0;
        t            = cyc;
        @(negedge clk);
        start = 1'b0;
        n     = 1;
        edges = 0;
        if (bad) begin
            chk("inv_valid_t1", result_valid, 1);
            chk("inv_osc_en", osc_en, 0);
        end else begin
            while (!result_valid && n < S + g + 20) begin
                chk("meas_osc_en", osc_en, 32'(1) << s);
                chk("meas_busy", busy, 1);
                start        = 1'($urandom_range(0, 1));
                sel          = 3'($urandom_range(0, 7));
                result_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                n++;
            end
            start        = 1'b0;
            result_ready = 1'b0;
            chk("done_latency", n, S + g + 1);
            for (int m = t + S - 1; m <= t + S + g - 2; m++)
                if (hist[m % HN][s] && !hist[(m - 1) % HN][s]) edges++;
        end
        exp_res   = (edges > 65535) ? 16'hFFFF : 16'(edges);
        exp_res_s = (edges > 15) ? 4'hF : 4'(edges);
        for (int i = 0; i <= hold; i++) begin
            chk("res_valid", result_valid, 1);
            chk("res_value", result, exp_res);
            chk("res_ovf", overflow, edges > 65535);
            chk("res_err", err, bad);
            chk("res_busy", busy, 1);
            chk("res_valid_s", result_valid_s, 1);
            chk("res_value_s", result_s, exp_res_s);
            chk("res_ovf_s", overflow_s, edges > 15);
            chk("res_err_s", err_s, bad);
            if (i < hold) begin
                start = 1'($urandom_range(0, 1));
                sel   = 3'($urandom_range(0, 3));
                @(negedge clk);
            end
        end
        if (nominal) chk("nominal_range", (result >= 16'd24) && (result <= 16'd26), 1);
        result_ready = 1'b1;
        start        = hs_start;
        sel          = 3'd1;
        gate_len     = 16'd5;
        @(negedge clk);
        chk("hs_valid_drop", result_valid, 0);
        chk("hs_idle", busy, 0);
        chk("hs_osc_en", osc_en, 0);
        chk("hs_valid_drop_s", result_valid_s, 0);
        start        = 1'b0;
        result_ready = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b1;
        sel          = 3'd2;
        gate_len     = 16'd10;
        result_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_osc_en", osc_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_err", err, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_all_s", {osc_en_s, busy_s, result_s, overflow_s, err_s, result_valid_s}, 0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);

        tap_mode = 0;
        run_meas(2, 100, 0, 1'b0, 1'b1);
        run_meas(2, 60, 1, 1'b0, 1'b0);
        run_meas(2, 64, 1, 1'b0, 1'b0);
        run_meas(5, 50, 2, 1'b0, 1'b0);
        run_meas(1, 0, 2, 1'b0, 1'b0);
        run_meas(0, 30, 20, 1'b1, 1'b0);
        run_meas(3, 40, 0, 1'b0, 1'b0);
        tap_mode = 2;
        run_meas(1, 1, 0, 1'b0, 1'b0);
        run_meas(3, 50, 0, 1'b0, 1'b0);

        tap_mode = 0;
        start    = 1'b1;
        sel      = 3'd2;
        gate_len = 16'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (48) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_osc_en", osc_en, 4'b0100);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_osc_en", osc_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", result_valid, 0);
        chk("mid_rst_s", {osc_en_s, busy_s, result_valid_s}, 0);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_quiet", {busy, result_valid}, 0);
        end
        run_meas(2, 100, 3, 1'b0, 1'b1);

        for (int k = 0; k < 12; k++) begin
            tap_mode = $urandom_range(0, 3);
            run_meas($urandom_range(0, 4),
                     ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 200),
                     $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_osc_meter_ctrl.md
Name: ring_osc_meter_ctrl

Overview:
Measurement controller for a bank of ring oscillators. On request it enables one selected oscillator, waits a settle interval, then counts rising edges of that oscillator's tap over a programmable gate window of clk cycles. It returns the saturating edge count through a valid/ready result handshake and disables the oscillator when done. It sits between the register/config logic and the oscillator bank, and guarantees that at most one oscillator runs at any time.

Parameters:
NUM_OSC, 4, number of oscillator instances controlled (>=1)
SEL_W, 2, width of select field; SEL_W >= clog2(NUM_OSC), minimum 1
CNT_W, 16, edge-count result width
GATE_W, 16, gate-length width in clk cycles
SETTLE_CYCLES, 8, cycles oscillator runs before counting starts (>=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start  input  1  measurement request, sampled only in IDLE
sel  input  SEL_W  oscillator index, latched on accepted start
gate_len  input  GATE_W  gate window length in cycles, latched on accepted start
osc_tap  input  NUM_OSC  raw oscillator outputs, asynchronous to clk
osc_en  output  NUM_OSC  one-hot (or zero) oscillator enables, registered
busy  output  1  high whenever state != IDLE
result  output  CNT_W  edge count, valid while result_valid=1
overflow  output  1  count saturated at all-ones
err  output  1  request rejected (sel >= NUM_OSC or gate_len == 0)
result_valid  output  1  result available
result_ready  input  1  consumer accepts result

Behaviour:
- Reset (rst=1 at posedge clk): state=IDLE; osc_en=0, busy=0, result=0, overflow=0, err=0, result_valid=0; sync/edge flops=0. Reset mid-measurement aborts with no result, and osc_en falls at that same edge.
- States: IDLE, SETTLE, MEASURE, DONE. All outputs registered.
- IDLE: start=1 at edge t latches sel/gate_len.
  - Invalid request (sel >= NUM_OSC or gate_len==0): go to DONE. At t+1: result=0, overflow=0, err=1, result_valid=1. osc_en stays 0.
  - Valid request: go to SETTLE. osc_en[sel]=1 from t+1. Clear counter, overflow and err.
- SETTLE: lasts exactly SETTLE_CYCLES cycles (t+1..t+S), then MEASURE. No counting occurs.
- Edge detection: osc_tap[sel_latched] feeds a 2-flop synchronizer and then a prev flop. Edge = sync2 & ~prev. The flops run in every state; the edge is used only in MEASURE. Maximum countable tap frequency is clk/2; faster inputs alias, and this is documented and not flagged.
- MEASURE: lasts exactly gate_len cycles (t+S+1..t+S+G). Counter increments by 1 per cycle with edge=1. At all-ones the counter holds and overflow is set (sticky for this measurement). After the last gate cycle, go to DONE.
- DONE (valid path): at t+S+G+1, osc_en=0, result=count, result_valid=1. result, overflow and err hold stable until result_ready=1 is sampled while result_valid=1. At that edge, result_valid falls, state returns to IDLE and busy falls.
- result_ready is ignored when result_valid=0.
- start is ignored in SETTLE, MEASURE and DONE, including start asserted in the same cycle as a completing handshake. It must be asserted again in IDLE.
- Back-to-back: a start in the first IDLE cycle after the handshake is accepted normally.
- Invariant: popcount(osc_en) <= 1 at all times. osc_en is nonzero only in SETTLE/MEASURE.
- gate_len counter uses GATE_W bits and decrements to zero; there is no wrap. gate_len = all-ones gives 2^GATE_W-1 cycles.

Test Plan:
1. Reset defaults: hold rst 3 cycles with start=1 -> all outputs 0, state IDLE, no osc_en.
2. Nominal count: sel=2, gate_len=100, S=8; tap toggles every 2 clk (period 4) -> osc_en=4'b0100 cycles t+1..t+108; result_valid at t+109; result in 25±1, overflow=0, err=0.
3. Saturation: CNT_W=4, gate_len=100, tap period 4 -> result=4'hF, overflow=1.
4. Invalid requests: sel=5 with NUM_OSC=4 (SEL_W=3) -> result_valid at t+1, err=1, result=0, osc_en never nonzero. Repeat with gate_len=0 -> same response.
5. Handshake/backpressure: hold result_ready=0 for 20 cycles -> result stable, busy=1, start pulses ignored. Then ready=1 with start=1 in the same cycle -> return to IDLE and start not accepted. Start on the next cycle is accepted.
6. Reset mid-MEASURE: assert rst at cycle t+50 of the test-2 run -> osc_en=0 and busy=0 after that edge, no result_valid. A subsequent request completes normally.
